// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, bundle layout and control bundle type for the pipeline control unit.
package ctrl_pkg;
  localparam int W_OP      = 6;
  localparam int W_FUNCT   = 6;
  localparam int W_REG     = 5;
  localparam int W_REGDEST = 2;
  localparam int W_MEM     = 6;
  localparam int W_WB      = 3;
  localparam logic [W_OP-1:0] OP_RTYPE = 6'b000000;
  localparam logic [W_OP-1:0] OP_ADDI  = 6'b001000;
  localparam logic [W_OP-1:0] OP_LW    = 6'b100011;
  localparam logic [W_OP-1:0] OP_LWU   = 6'b100111;
  localparam logic [W_OP-1:0] OP_LH    = 6'b100001;
  localparam logic [W_OP-1:0] OP_LHU   = 6'b100101;
  localparam logic [W_OP-1:0] OP_LB    = 6'b100000;
  localparam logic [W_OP-1:0] OP_LBU   = 6'b100100;
  localparam logic [W_OP-1:0] OP_SW    = 6'b101011;
  localparam logic [W_OP-1:0] OP_SH    = 6'b101001;
  localparam logic [W_OP-1:0] OP_SB    = 6'b101000;
  localparam logic [W_OP-1:0] OP_BEQ   = 6'b000100;
  localparam logic [W_OP-1:0] OP_BNE   = 6'b000101;
  localparam logic [W_OP-1:0] OP_JAL   = 6'b000011;
  localparam logic [W_FUNCT-1:0] FN_JR = 6'b001000;
  localparam int MEM_SIGN    = 5;
  localparam int MEM_READ    = 4;
  localparam int MEM_WRITE   = 3;
  localparam int WB_REGWRITE = 2;
  localparam logic [W_REGDEST-1:0] RD_RD  = 2'b00;
  localparam logic [W_REGDEST-1:0] RD_RT  = 2'b01;
  localparam logic [W_REGDEST-1:0] RD_R31 = 2'b10;
  typedef struct packed {
    logic [W_REGDEST-1:0] reg_dest;
    logic                 tipe_i;
    logic                 branch;
    logic [W_MEM-1:0]     mem;
    logic [W_WB-1:0]      wb;
  } ctrl_t;
  function automatic ctrl_t ld_ctrl(input logic [W_MEM-1:0] m);
    return '{RD_RT, 1'b1, 1'b0, m, 3'b101};
  endfunction
  function automatic ctrl_t st_ctrl(input logic [W_MEM-1:0] m);
    return '{RD_RD, 1'b1, 1'b0, m, 3'b000};
  endfunction
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode/funct to control bundle table.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [W_OP-1:0]    i_opcode,
  input  logic [W_FUNCT-1:0] i_funct,
  output ctrl_t              o_ctrl,
  output logic               o_illegal,
  output logic               o_uses_rt
);
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    o_uses_rt = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.branch = i_funct == FN_JR;
        o_ctrl.wb     = i_funct == FN_JR ? 3'b000 : 3'b100;
        o_uses_rt     = 1'b1;
      end
      OP_ADDI: o_ctrl = '{RD_RT, 1'b1, 1'b0, 6'b0, 3'b100};
      OP_LW:   o_ctrl = ld_ctrl(6'b110100);
      OP_LWU:  o_ctrl = ld_ctrl(6'b010100);
      OP_LH:   o_ctrl = ld_ctrl(6'b110010);
      OP_LHU:  o_ctrl = ld_ctrl(6'b010010);
      OP_LB:   o_ctrl = ld_ctrl(6'b110001);
      OP_LBU:  o_ctrl = ld_ctrl(6'b010001);
      OP_SW: begin o_ctrl = st_ctrl(6'b001100); o_uses_rt = 1'b1; end
      OP_SH: begin o_ctrl = st_ctrl(6'b001010); o_uses_rt = 1'b1; end
      OP_SB: begin o_ctrl = st_ctrl(6'b001001); o_uses_rt = 1'b1; end
      OP_BEQ, OP_BNE: begin o_ctrl.branch = 1'b1; o_uses_rt = 1'b1; end
      OP_JAL:  o_ctrl = '{RD_R31, 1'b0, 1'b0, 6'b0, 3'b110};
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_pipeline_unit.sv
// ctrl_pipeline_unit: ID decode, control bundle staging through EX/MEM/WB,
// load-use stall, flush bubbles and a saturating bubble counter.
module ctrl_pipeline_unit
  import ctrl_pkg::*;
#(
  parameter int NB_OP      = W_OP,
  parameter int NB_FUNCT   = W_FUNCT,
  parameter int NB_REG     = W_REG,
  parameter int N_REGDEST  = W_REGDEST,
  parameter int NB_MEM_SIG = W_MEM,
  parameter int NB_WB_SIG  = W_WB,
  parameter int NB_CNT     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NB_OP-1:0]      opcode,
  input  logic [NB_FUNCT-1:0]   funct,
  input  logic [NB_REG-1:0]     rs,
  input  logic [NB_REG-1:0]     rt,
  input  logic [NB_REG-1:0]     rd,
  input  logic                  ex_flush,
  input  logic                  halt,
  output logic                  stall,
  output logic                  if_id_flush,
  output logic                  illegal,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [N_REGDEST-1:0]  ex_regDest_signal,
  output logic                  ex_tipeI,
  output logic                  ex_branch,
  output logic [NB_MEM_SIG-1:0] ex_mem_signals,
  output logic [NB_MEM_SIG-1:0] mem_mem_signals,
  output logic [NB_WB_SIG-1:0]  ex_wb_signals,
  output logic [NB_WB_SIG-1:0]  mem_wb_signals,
  output logic [NB_WB_SIG-1:0]  wb_wb_signals,
  output logic [NB_REG-1:0]     ex_dest,
  output logic [NB_REG-1:0]     mem_dest,
  output logic [NB_REG-1:0]     wb_dest,
  output logic [NB_CNT-1:0]     bubble_count
);
  ctrl_t                 w_dec;
  logic                  w_illegal;
  logic                  w_uses_rt;
  logic                  w_take;
  logic [NB_REG-1:0]     w_dest;
  ctrl_t                 r_ex;
  logic                  r_ex_valid;
  logic [NB_REG-1:0]     r_ex_dest;
  logic                  r_mem_valid;
  logic [NB_MEM_SIG-1:0] r_mem_mem;
  logic [NB_WB_SIG-1:0]  r_mem_wb;
  logic [NB_REG-1:0]     r_mem_dest;
  logic                  r_wb_valid;
  logic [NB_WB_SIG-1:0]  r_wb_wb;
  logic [NB_REG-1:0]     r_wb_dest;
  logic [NB_CNT-1:0]     r_cnt;

  ctrl_decoder u_dec (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_ctrl   (w_dec),
    .o_illegal(w_illegal),
    .o_uses_rt(w_uses_rt)
  );

  assign w_dest = !w_dec.wb[WB_REGWRITE] ? '0 :
                  w_dec.reg_dest == RD_RT  ? rt :
                  w_dec.reg_dest == RD_R31 ? {NB_REG{1'b1}} : rd;
  // Flush and halt override the hazard so a squashed slot never counts twice.
  assign stall = id_valid & r_ex_valid & r_ex.mem[MEM_READ] & (r_ex_dest != '0) &
                 (r_ex_dest == rs | (r_ex_dest == rt & w_uses_rt)) & !ex_flush & !halt;
  assign if_id_flush = ex_flush & !halt;
  assign illegal     = id_valid & w_illegal;
  assign w_take      = id_valid & !w_illegal & !ex_flush & !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex        <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_dest   <= '0;
      r_mem_valid <= 1'b0;
      r_mem_mem   <= '0;
      r_mem_wb    <= '0;
      r_mem_dest  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_wb     <= '0;
      r_wb_dest   <= '0;
      r_cnt       <= '0;
    end else if (!halt) begin
      r_ex        <= w_take ? w_dec : '0;
      r_ex_valid  <= w_take;
      r_ex_dest   <= w_take ? w_dest : '0;
      r_mem_valid <= r_ex_valid;
      r_mem_mem   <= r_ex.mem;
      r_mem_wb    <= r_ex.wb;
      r_mem_dest  <= r_ex_dest;
      r_wb_valid  <= r_mem_valid;
      r_wb_wb     <= r_mem_wb;
      r_wb_dest   <= r_mem_dest;
      if ((ex_flush | stall) & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ex_valid          = r_ex_valid;
  assign ex_regDest_signal = r_ex.reg_dest;
  assign ex_tipeI          = r_ex.tipe_i;
  assign ex_branch         = r_ex.branch;
  assign ex_mem_signals    = r_ex.mem;
  assign ex_wb_signals     = r_ex.wb;
  assign ex_dest           = r_ex_dest;
  assign mem_valid         = r_mem_valid;
  assign mem_mem_signals   = r_mem_mem;
  assign mem_wb_signals    = r_mem_wb;
  assign mem_dest          = r_mem_dest;
  assign wb_valid          = r_wb_valid;
  assign wb_wb_signals     = r_wb_wb;
  assign wb_dest           = r_wb_dest;
  assign bubble_count      = r_cnt;
endmodule

// File: tb/tb_ctrl_pipeline_unit.sv
// tb_ctrl_pipeline_unit: reference-model and WB scoreboard bench for ctrl_pipeline_unit.
module tb_ctrl_pipeline_unit;
  typedef struct packed {
    logic       v;
    logic [1:0] rds;
    logic       ti;
    logic       br;
    logic [5:0] mem;
    logic [2:0] wb;
    logic [4:0] dest;
  } ent_t;

  localparam logic [5:0] RT_OP = 6'b000000, ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  logic clock = 1'b0;
  logic reset, id_valid, ex_flush, halt;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic stall, if_id_flush, illegal, ex_valid, mem_valid, wb_valid, ex_tipeI, ex_branch;
  logic [1:0] ex_regDest_signal;
  logic [5:0] ex_mem_signals, mem_mem_signals;
  logic [2:0] ex_wb_signals, mem_wb_signals, wb_wb_signals;
  logic [4:0] ex_dest, mem_dest, wb_dest;
  logic [15:0] bubble_count;

  int n_tests = 0, n_fail = 0;
  ent_t m_ex, m_mem, m_wb;
  int m_cnt;
  ent_t exp_q[$];
  logic last_acc, last_es;

  always #5 clock = ~clock;

  ctrl_pipeline_unit dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .ex_flush(ex_flush), .halt(halt),
    .stall(stall), .if_id_flush(if_id_flush), .illegal(illegal),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_regDest_signal(ex_regDest_signal), .ex_tipeI(ex_tipeI), .ex_branch(ex_branch),
    .ex_mem_signals(ex_mem_signals), .mem_mem_signals(mem_mem_signals),
    .ex_wb_signals(ex_wb_signals), .mem_wb_signals(mem_wb_signals), .wb_wb_signals(wb_wb_signals),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_dec(input logic [5:0] op, input logic [5:0] f, input logic [4:0] t,
                                   input logic [4:0] d, output logic ill, output logic urt);
    ent_t e;
    e = '0; ill = 1'b0; urt = 1'b0;
    case (op)
      6'b000000: begin urt = 1'b1; if (f == F_JR) e.br = 1'b1; else e.wb = 3'b100; end
      6'b001000: begin e.rds = 2'b01; e.ti = 1'b1; e.wb = 3'b100; end
      6'b100011: e.mem = 6'b110100;
      6'b100111: e.mem = 6'b010100;
      6'b100001: e.mem = 6'b110010;
      6'b100101: e.mem = 6'b010010;
      6'b100000: e.mem = 6'b110001;
      6'b100100: e.mem = 6'b010001;
      6'b101011: e.mem = 6'b001100;
      6'b101001: e.mem = 6'b001010;
      6'b101000: e.mem = 6'b001001;
      6'b000100, 6'b000101: begin e.br = 1'b1; urt = 1'b1; end
      6'b000011: begin e.rds = 2'b10; e.wb = 3'b110; end
      default: ill = 1'b1;
    endcase
    if (e.mem[4]) begin e.rds = 2'b01; e.ti = 1'b1; e.wb = 3'b101; end
    if (e.mem[3]) begin e.ti = 1'b1; urt = 1'b1; end
    e.dest = !e.wb[2] ? 5'd0 : e.rds == 2'b01 ? t : e.rds == 2'b10 ? 5'd31 : d;
    e.v = 1'b1;
    return e;
  endfunction

  task automatic cycle();
    ent_t d, e;
    logic ill, urt, es;
    d = ref_dec(opcode, funct, rt, rd, ill, urt);
    @(negedge clock);
    es = id_valid && m_ex.v && m_ex.mem[4] && m_ex.dest != 0 &&
         (m_ex.dest == rs || (m_ex.dest == rt && urt)) && !ex_flush && !halt;
    chk("stall", stall, es);
    chk("if_id_flush", if_id_flush, ex_flush && !halt);
    chk("illegal", illegal, id_valid && ill);
    last_es = es;
    last_acc = 1'b0;
    @(posedge clock);
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
      exp_q.delete();
    end else if (!halt) begin
      m_wb = m_mem;
      m_mem = m_ex;
      last_acc = id_valid && !ill && !ex_flush && !es;
      m_ex = last_acc ? d : '0;
      if (last_acc) exp_q.push_back(d);
      if ((ex_flush || es) && m_cnt < 65535) m_cnt++;
    end
    #1;
    chk("ex_valid", ex_valid, m_ex.v);
    chk("ex_regdest", ex_regDest_signal, m_ex.rds);
    chk("ex_tipei", ex_tipeI, m_ex.ti);
    chk("ex_branch", ex_branch, m_ex.br);
    chk("ex_mem", ex_mem_signals, m_ex.mem);
    chk("ex_wb", ex_wb_signals, m_ex.wb);
    chk("ex_dest", ex_dest, m_ex.dest);
    chk("mem_valid", mem_valid, m_mem.v);
    chk("mem_mem", mem_mem_signals, m_mem.mem);
    chk("mem_wb", mem_wb_signals, m_mem.wb);
    chk("mem_dest", mem_dest, m_mem.dest);
    chk("wb_valid", wb_valid, m_wb.v);
    chk("bubble_count", bubble_count, m_cnt);
    if (wb_valid === 1'b1 && !halt) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_wb", wb_wb_signals, e.wb);
        chk("sb_dest", wb_dest, e.dest);
      end
    end else if (wb_valid !== 1'b1) begin
      chk("wb_idle_wb", wb_wb_signals, 0);
      chk("wb_idle_dest", wb_dest, 0);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] f, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d);
    id_valid = 1'b1; opcode = op; funct = f; rs = s; rt = t; rd = d;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    int k;
    set_in(op, f, s, t, d);
    cycle();
    k = 0;
    while (last_es && k < 4) begin cycle(); k++; end
    if (last_es) chk("stall_bound", 1, 0);
  endtask

  task automatic nop();
    id_valid = 1'b0;
    cycle();
  endtask

  logic [5:0] ops [12] = '{6'b100111, 6'b100001, 6'b100101, 6'b100000, 6'b100100, 6'b101001,
                           6'b101000, 6'b000100, 6'b000101, 6'b000011, 6'b000000, 6'b101011};

  initial begin
    int held;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    reset = 1'b1; ex_flush = 1'b0; halt = 1'b0;
    id_valid = 1'b0; opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    cycle(); cycle();
    chk("rst_cnt", bubble_count, 0);
    reset = 1'b0;
    issue(ADDI, 6'd0, 5'd1, 5'd5, 5'd0);
    chk("addi_dest", ex_dest, 5);
    chk("addi_rdsel", ex_regDest_signal, 2'b01);
    nop(); nop();
    chk("addi_wb", wb_wb_signals, 3'b100);
    chk("addi_wb_dest", wb_dest, 5);
    issue(LW, 6'd0, 5'd0, 5'd3, 5'd0);
    issue(RT_OP, F_ADD, 5'd3, 5'd4, 5'd7);
    chk("lu_cnt", bubble_count, 1);
    chk("lu_dest_rd", ex_dest, 7);
    issue(LW, 6'd0, 5'd1, 5'd0, 5'd0);
    issue(RT_OP, F_ADD, 5'd0, 5'd0, 5'd8);
    chk("r0_cnt", bubble_count, 1);
    issue(LW, 6'd0, 5'd1, 5'd3, 5'd0);
    issue(SW, 6'd0, 5'd2, 5'd3, 5'd0);
    chk("sw_cnt", bubble_count, 2);
    issue(LW, 6'd0, 5'd1, 5'd6, 5'd0);
    issue(ADDI, 6'd0, 5'd2, 5'd6, 5'd0);
    chk("addi_rt_cnt", bubble_count, 2);
    issue(LW, 6'd0, 5'd1, 5'd3, 5'd0);
    set_in(RT_OP, F_ADD, 5'd3, 5'd4, 5'd9);
    ex_flush = 1'b1;
    cycle();
    ex_flush = 1'b0;
    chk("flush_bubble", ex_valid, 0);
    chk("flush_cnt", bubble_count, 3);
    nop();
    for (int i = 0; i < 12; i++) issue(ops[i], F_JR, 5'd10, 5'd9, 5'd11);
    issue(ADDI, 6'd0, 5'd1, 5'd12, 5'd0);
    set_in(RT_OP, F_ADD, 5'd1, 5'd2, 5'd13);
    halt = 1'b1;
    cycle();
    held = ex_dest;
    ex_flush = 1'b1;
    cycle();
    ex_flush = 1'b0;
    cycle();
    chk("halt_hold", ex_dest, held);
    halt = 1'b0;
    cycle();
    chk("halt_resume", ex_dest, 13);
    issue(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
    chk("illegal_bubble", ex_valid, 0);
    issue(ADDI, 6'd0, 5'd1, 5'd14, 5'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    nop(); nop(); nop();
    chk("q_drained", exp_q.size(), 0);
    ex_flush = 1'b1;
    id_valid = 1'b0;
    repeat (65540) @(posedge clock);
    #1;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 65535;
    chk("sat_cnt", bubble_count, 16'hFFFF);
    ex_flush = 1'b0;
    nop();
    issue(LW, 6'd0, 5'd1, 5'd3, 5'd0);
    issue(RT_OP, F_ADD, 5'd3, 5'd4, 5'd7);
    chk("sat_hold", bubble_count, 16'hFFFF);
    nop(); nop(); nop();
    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
